// File: rtl/lsu_dccm_pkg.sv
// Shared types and helpers for the DCCM bank controller slice.
// Bank decode, scrub state encoding and the default full-word width.
package lsu_dccm_pkg;

    localparam int DCCM_DATA_WIDTH = 32;
    localparam int DCCM_ECC_WIDTH  = 7;
    localparam int FDATA_WIDTH     = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } scrub_state_e;

    // Bank index sits just above the byte-within-word bits.
    function automatic logic [31:0] bank_index(input logic [31:0] addr,
                                               input int          bw,
                                               input int          bb);
        return (addr >> bw) & ((32'd1 << bb) - 32'd1);
    endfunction

endpackage

// File: rtl/lsu_dccm_wr_arb.sv
// DCCM write arbitration: picks scrub or store, detects load/write bank
// conflicts, bounds write starvation and runs the scrub pending FSM.
module lsu_dccm_wr_arb
    import lsu_dccm_pkg::*;
#(
    parameter int NUM_BANKS    = 2,
    parameter int DATA_WIDTH   = DCCM_DATA_WIDTH,
    parameter int ECC_WIDTH    = DCCM_ECC_WIDTH,
    parameter int ADDR_BITS    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            freeze,
    input  logic                            ld_valid,
    input  logic [NUM_BANKS-1:0]            ld_bank_set,
    input  logic                            st_req,
    input  logic [ADDR_BITS-1:0]            st_addr,
    input  logic [DATA_WIDTH-1:0]           st_data,
    input  logic [ECC_WIDTH-1:0]            st_ecc,
    input  logic                            scrub_req,
    input  logic [ADDR_BITS-1:0]            scrub_addr,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] scrub_data,
    output logic                            wr_issue,
    output logic [NUM_BANKS-1:0]            wr_bank_oh,
    output logic [ADDR_BITS-1:0]            wr_addr,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0] wr_data,
    output logic                            ld_block,
    output logic                            st_commit,
    output logic                            scrub_busy,
    output logic                            scrub_done
);

    localparam int FW = DATA_WIDTH + ECC_WIDTH;
    localparam int BW = $clog2(DATA_WIDTH / 8);
    localparam int BB = $clog2(NUM_BANKS);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    scrub_state_e         state_q;
    scrub_state_e         state_d;
    logic [ADDR_BITS-1:0] scrub_addr_q;
    logic [FW-1:0]        scrub_data_q;
    logic [SW-1:0]        starve_cnt;
    logic                 active;
    logic                 scrub_sel;
    logic                 st_elig;
    logic                 wr_pend;
    logic                 conflict;
    logic                 write_wins;
    logic [BB-1:0]        wr_bank;

    // A scrub arriving this cycle holds the store off so it cannot be overtaken.
    always_comb begin
        active     = !freeze && !rst;
        scrub_sel  = (state_q == PEND);
        st_elig    = st_req && (state_q == IDLE) && !scrub_req;
        wr_pend    = scrub_sel || st_elig;
        wr_addr    = scrub_sel ? scrub_addr_q : st_addr;
        wr_data    = scrub_sel ? scrub_data_q : {st_ecc, st_data};
        wr_bank    = BB'(bank_index(32'(wr_addr), BW, BB));
        conflict   = wr_pend && ld_valid && ld_bank_set[wr_bank];
        write_wins = conflict && (starve_cnt == STARVE_MAX);
        wr_issue   = active && wr_pend && (!conflict || write_wins);
        ld_block   = active && write_wins;
        st_commit  = wr_issue && !scrub_sel;
        scrub_done = wr_issue && scrub_sel;
        scrub_busy = scrub_sel;
        wr_bank_oh = '0;
        if (wr_issue) begin
            wr_bank_oh[wr_bank] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scrub_req) state_d = PEND;
            PEND:    if (wr_issue)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (!freeze) begin
            state_q <= state_d;
        end
    end

    // Starve count only advances while a blocked write loses to a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_addr_q <= '0;
            scrub_data_q <= '0;
            starve_cnt   <= '0;
        end else if (!freeze) begin
            if (state_q == IDLE && scrub_req) begin
                scrub_addr_q <= scrub_addr;
                scrub_data_q <= scrub_data;
            end
            if (wr_issue) begin
                starve_cnt <= '0;
            end else if (conflict && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_dccm_bank_ctl.sv
// Parametrised DCCM port controller: per-bank read/write steering and the
// DC1->DC2->DC3 read data pipeline.
module lsu_dccm_bank_ctl
    import lsu_dccm_pkg::*;
#(
    parameter int NUM_BANKS    = 2,
    parameter int DATA_WIDTH   = DCCM_DATA_WIDTH,
    parameter int ECC_WIDTH    = DCCM_ECC_WIDTH,
    parameter int ADDR_BITS    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      freeze,
    input  logic                                      ld_valid_dc1,
    input  logic [ADDR_BITS-1:0]                      ld_addr_dc1,
    input  logic [ADDR_BITS-1:0]                      ld_end_addr_dc1,
    output logic                                      ld_stall_dc1,
    input  logic                                      st_req,
    input  logic [ADDR_BITS-1:0]                      st_addr,
    input  logic [DATA_WIDTH-1:0]                     st_data,
    input  logic [ECC_WIDTH-1:0]                      st_ecc,
    output logic                                      st_commit,
    input  logic                                      scrub_req,
    input  logic [ADDR_BITS-1:0]                      scrub_addr,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]           scrub_data,
    output logic                                      scrub_busy,
    output logic                                      scrub_done,
    output logic [NUM_BANKS-1:0]                      bank_rden,
    output logic [NUM_BANKS-1:0]                      bank_wren,
    output logic [NUM_BANKS*ADDR_BITS-1:0]            bank_addr,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]           bank_wr_data,
    input  logic [NUM_BANKS*(DATA_WIDTH+ECC_WIDTH)-1:0] bank_rd_data,
    output logic                                      rd_valid_dc3,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]           rd_data_lo_dc3,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]           rd_data_hi_dc3
);

    localparam int FW = DATA_WIDTH + ECC_WIDTH;
    localparam int BW = $clog2(DATA_WIDTH / 8);
    localparam int BB = $clog2(NUM_BANKS);

    logic [BB-1:0]          lo_bank;
    logic [BB-1:0]          hi_bank;
    logic [BB-1:0]          lo_bank_dc2;
    logic [BB-1:0]          hi_bank_dc2;
    logic [NUM_BANKS-1:0]   ld_bank_set;
    logic [NUM_BANKS-1:0]   wr_bank_oh;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [FW-1:0]          wr_data;
    logic                   wr_issue;
    logic                   ld_block;
    logic                   ld_issue;
    logic                   rden_dc2;

    always_comb begin
        lo_bank     = BB'(bank_index(32'(ld_addr_dc1), BW, BB));
        hi_bank     = BB'(bank_index(32'(ld_end_addr_dc1), BW, BB));
        ld_bank_set = '0;
        ld_bank_set[lo_bank] = 1'b1;
        ld_bank_set[hi_bank] = 1'b1;
    end

    lsu_dccm_wr_arb #(
        .NUM_BANKS    (NUM_BANKS),
        .DATA_WIDTH   (DATA_WIDTH),
        .ECC_WIDTH    (ECC_WIDTH),
        .ADDR_BITS    (ADDR_BITS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wr_arb (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .ld_valid    (ld_valid_dc1),
        .ld_bank_set (ld_bank_set),
        .st_req      (st_req),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ecc      (st_ecc),
        .scrub_req   (scrub_req),
        .scrub_addr  (scrub_addr),
        .scrub_data  (scrub_data),
        .wr_issue    (wr_issue),
        .wr_bank_oh  (wr_bank_oh),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ld_block    (ld_block),
        .st_commit   (st_commit),
        .scrub_busy  (scrub_busy),
        .scrub_done  (scrub_done)
    );

    // The write bank never overlaps an issued load, so priority order is free.
    always_comb begin
        ld_issue     = ld_valid_dc1 && !freeze && !rst && !ld_block;
        ld_stall_dc1 = ld_valid_dc1 && !rst && (freeze || ld_block);
        bank_rden    = ld_issue ? ld_bank_set : '0;
        bank_wren    = wr_bank_oh;
        bank_wr_data = wr_issue ? wr_data : '0;
        bank_addr    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_bank_oh[b]) begin
                bank_addr[b*ADDR_BITS +: ADDR_BITS] = wr_addr;
            end else if (ld_issue && BB'(b) == lo_bank) begin
                bank_addr[b*ADDR_BITS +: ADDR_BITS] = ld_addr_dc1;
            end else if (ld_issue && BB'(b) == hi_bank) begin
                bank_addr[b*ADDR_BITS +: ADDR_BITS] = ld_end_addr_dc1;
            end
        end
    end

    // Bank indices travel with the read so DC3 can pick lo/hi words.
    always_ff @(posedge clk) begin
        if (rst) begin
            rden_dc2       <= 1'b0;
            lo_bank_dc2    <= '0;
            hi_bank_dc2    <= '0;
            rd_valid_dc3   <= 1'b0;
            rd_data_lo_dc3 <= '0;
            rd_data_hi_dc3 <= '0;
        end else if (!freeze) begin
            rden_dc2     <= ld_issue;
            lo_bank_dc2  <= lo_bank;
            hi_bank_dc2  <= hi_bank;
            rd_valid_dc3 <= rden_dc2;
            if (rden_dc2) begin
                rd_data_lo_dc3 <= bank_rd_data[int'(lo_bank_dc2)*FW +: FW];
                rd_data_hi_dc3 <= bank_rd_data[int'(hi_bank_dc2)*FW +: FW];
            end
        end
    end

endmodule

// File: tb/tb_lsu_dccm_bank_ctl.sv
// Self-checking bench for lsu_dccm_bank_ctl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_lsu_dccm_bank_ctl;

    localparam int NB = 2;
    localparam int DW = 32;
    localparam int EW = 7;
    localparam int AB = 16;
    localparam int SL = 4;
    localparam int FW = DW + EW;

    logic            clk = 1'b0;
    logic            rst;
    logic            freeze;
    logic            ld_valid_dc1;
    logic [AB-1:0]   ld_addr_dc1;
    logic [AB-1:0]   ld_end_addr_dc1;
    logic            ld_stall_dc1;
    logic            st_req;
    logic [AB-1:0]   st_addr;
    logic [DW-1:0]   st_data;
    logic [EW-1:0]   st_ecc;
    logic            st_commit;
    logic            scrub_req;
    logic [AB-1:0]   scrub_addr;
    logic [FW-1:0]   scrub_data;
    logic            scrub_busy;
    logic            scrub_done;
    logic [NB-1:0]   bank_rden;
    logic [NB-1:0]   bank_wren;
    logic [NB*AB-1:0] bank_addr;
    logic [FW-1:0]   bank_wr_data;
    logic [NB*FW-1:0] bank_rd_data;
    logic            rd_valid_dc3;
    logic [FW-1:0]   rd_data_lo_dc3;
    logic [FW-1:0]   rd_data_hi_dc3;

    logic [FW-1:0]   bank_word [NB];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int              m_starve;
    int              m_tick;
    bit              m_pend;
    logic [AB-1:0]   m_saddr;
    logic [FW-1:0]   m_sdata;
    bit              m_rv;
    logic [FW-1:0]   m_lo;
    logic [FW-1:0]   m_hi;
    logic [AB-1:0]   iss_lo [int];
    logic [AB-1:0]   iss_hi [int];
    bit              m_ld_go;
    bit              m_wr_go;
    bit              m_hit;

    logic [NB-1:0]   e_rden;
    logic [NB-1:0]   e_wren;
    logic [NB*AB-1:0] e_addr;
    logic [FW-1:0]   e_wdata;
    bit              e_stall;
    bit              e_commit;
    bit              e_sdone;

    lsu_dccm_bank_ctl #(
        .NUM_BANKS    (NB),
        .DATA_WIDTH   (DW),
        .ECC_WIDTH    (EW),
        .ADDR_BITS    (AB),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .ld_valid_dc1    (ld_valid_dc1),
        .ld_addr_dc1     (ld_addr_dc1),
        .ld_end_addr_dc1 (ld_end_addr_dc1),
        .ld_stall_dc1    (ld_stall_dc1),
        .st_req          (st_req),
        .st_addr         (st_addr),
        .st_data         (st_data),
        .st_ecc          (st_ecc),
        .st_commit       (st_commit),
        .scrub_req       (scrub_req),
        .scrub_addr      (scrub_addr),
        .scrub_data      (scrub_data),
        .scrub_busy      (scrub_busy),
        .scrub_done      (scrub_done),
        .bank_rden       (bank_rden),
        .bank_wren       (bank_wren),
        .bank_addr       (bank_addr),
        .bank_wr_data    (bank_wr_data),
        .bank_rd_data    (bank_rd_data),
        .rd_valid_dc3    (rd_valid_dc3),
        .rd_data_lo_dc3  (rd_data_lo_dc3),
        .rd_data_hi_dc3  (rd_data_hi_dc3)
    );

    always #5 clk = ~clk;

    // Stored word content is a fixed function of the word address.
    function automatic logic [FW-1:0] word_of(input logic [AB-1:0] a);
        logic [15:0] w;
        w = 16'(a >> 2);
        return {7'(w * 16'd5 + 16'd1), w ^ 16'hA5C3, 16'(w * 16'd7 + 16'd3)};
    endfunction

    // Bank macros: read data appears the cycle after rden and then holds.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_rden[b]) bank_word[b] <= word_of(bank_addr[b*AB +: AB]);
        end
    end

    always_comb begin
        bank_rd_data = '0;
        for (int b = 0; b < NB; b++) bank_rd_data[b*FW +: FW] = bank_word[b];
    end

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic setIdle();
        rst = 1'b0; freeze = 1'b0;
        ld_valid_dc1 = 1'b0; ld_addr_dc1 = '0; ld_end_addr_dc1 = '0;
        st_req = 1'b0; st_addr = '0; st_data = '0; st_ecc = '0;
        scrub_req = 1'b0; scrub_addr = '0; scrub_data = '0;
    endtask

    task automatic modelReset();
        m_starve = 0; m_tick = 0; m_pend = 1'b0; m_saddr = '0; m_sdata = '0;
        m_rv = 1'b0; m_lo = '0; m_hi = '0;
        iss_lo.delete(); iss_hi.delete();
    endtask

    task automatic modelEval();
        int sb, eb, wb;
        bit has_wr, is_scrub;
        logic [AB-1:0] wa;
        logic [FW-1:0] wd;
        e_rden = '0; e_wren = '0; e_addr = '0; e_wdata = '0;
        e_stall = 1'b0; e_commit = 1'b0; e_sdone = 1'b0;
        m_ld_go = 1'b0; m_wr_go = 1'b0; m_hit = 1'b0;
        if (rst) return;
        if (freeze) begin
            e_stall = ld_valid_dc1;
            return;
        end
        sb = (int'(ld_addr_dc1) / 4) % NB;
        eb = (int'(ld_end_addr_dc1) / 4) % NB;
        is_scrub = m_pend;
        has_wr = m_pend || (st_req && !scrub_req);
        wa = is_scrub ? m_saddr : st_addr;
        wd = is_scrub ? m_sdata : {st_ecc, st_data};
        wb = (int'(wa) / 4) % NB;
        m_hit = has_wr && ld_valid_dc1 && (wb == sb || wb == eb);
        if (!m_hit) begin
            m_ld_go = ld_valid_dc1;
            m_wr_go = has_wr;
        end else if (m_starve < SL) begin
            m_ld_go = 1'b1;
        end else begin
            m_wr_go = 1'b1;
        end
        e_stall = ld_valid_dc1 && !m_ld_go;
        if (m_ld_go) begin
            e_rden[sb] = 1'b1;
            e_rden[eb] = 1'b1;
            e_addr[sb*AB +: AB] = ld_addr_dc1;
            if (eb != sb) e_addr[eb*AB +: AB] = ld_end_addr_dc1;
        end
        if (m_wr_go) begin
            e_wren[wb] = 1'b1;
            e_addr[wb*AB +: AB] = wa;
            e_wdata = wd;
            e_commit = !is_scrub;
            e_sdone = is_scrub;
        end
    endtask

    task automatic modelUpdate();
        if (rst) begin
            modelReset();
            return;
        end
        if (freeze) return;
        if (m_wr_go) m_starve = 0;
        else if (m_hit) m_starve = m_starve + 1;
        if (m_pend && m_wr_go) begin
            m_pend = 1'b0;
        end else if (!m_pend && scrub_req) begin
            m_pend = 1'b1;
            m_saddr = scrub_addr;
            m_sdata = scrub_data;
        end
        if (m_ld_go) begin
            iss_lo[m_tick] = ld_addr_dc1;
            iss_hi[m_tick] = ld_end_addr_dc1;
        end
        m_tick++;
        if (iss_lo.exists(m_tick - 2)) begin
            m_rv = 1'b1;
            m_lo = word_of(iss_lo[m_tick - 2]);
            m_hi = word_of(iss_hi[m_tick - 2]);
        end else begin
            m_rv = 1'b0;
        end
    endtask

    task automatic checkAll();
        checkOutput("bank_rden",    64'(bank_rden),      64'(e_rden));
        checkOutput("bank_wren",    64'(bank_wren),      64'(e_wren));
        checkOutput("bank_addr",    64'(bank_addr),      64'(e_addr));
        checkOutput("bank_wr_data", 64'(bank_wr_data),   64'(e_wdata));
        checkOutput("ld_stall",     64'(ld_stall_dc1),   64'(e_stall));
        checkOutput("st_commit",    64'(st_commit),      64'(e_commit));
        checkOutput("scrub_done",   64'(scrub_done),     64'(e_sdone));
        checkOutput("scrub_busy",   64'(scrub_busy),     64'(m_pend));
        checkOutput("rd_valid",     64'(rd_valid_dc3),   64'(m_rv));
        checkOutput("rd_lo",        64'(rd_data_lo_dc3), 64'(m_lo));
        checkOutput("rd_hi",        64'(rd_data_hi_dc3), 64'(m_hi));
    endtask

    // Inputs are set just after a rising edge; this checks and advances one cycle.
    task automatic applyStimulus();
        #2;
        modelEval();
        checkAll();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    initial begin
        setIdle();
        modelReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus();

        // Aligned load to bank 0
        setIdle();
        ld_valid_dc1 = 1'b1; ld_addr_dc1 = 16'h0010; ld_end_addr_dc1 = 16'h0013;
        #1;
        checkOutput("aligned_rden", 64'(bank_rden), 64'h1);
        applyStimulus();
        setIdle(); applyStimulus();
        setIdle();
        #1;
        checkOutput("aligned_valid", 64'(rd_valid_dc3), 64'h1);
        checkOutput("aligned_lo_eq_hi", 64'(rd_data_lo_dc3), 64'(word_of(16'h0013)));
        applyStimulus();

        // Unaligned load spanning bank 1 then bank 0
        setIdle();
        ld_valid_dc1 = 1'b1; ld_addr_dc1 = 16'h0006; ld_end_addr_dc1 = 16'h0009;
        #1;
        checkOutput("unaligned_rden", 64'(bank_rden), 64'h3);
        applyStimulus();
        setIdle(); applyStimulus();
        setIdle(); applyStimulus();

        // Store to bank 1 alongside a load to bank 0
        setIdle();
        ld_valid_dc1 = 1'b1; ld_addr_dc1 = 16'h0010; ld_end_addr_dc1 = 16'h0013;
        st_req = 1'b1; st_addr = 16'h0004; st_data = 32'hCAFE_F00D; st_ecc = 7'h2A;
        #1;
        checkOutput("mix_wren", 64'(bank_wren), 64'h2);
        applyStimulus();

        // Loads keep hitting the store bank until the write is forced through
        for (int c = 0; c < SL + 1; c++) begin
            setIdle();
            ld_valid_dc1 = 1'b1; ld_addr_dc1 = 16'h0024; ld_end_addr_dc1 = 16'h0027;
            st_req = 1'b1; st_addr = 16'h0004; st_data = 32'h1234_5678; st_ecc = 7'h11;
            #1;
            checkOutput("starve_commit", 64'(st_commit), (c == SL) ? 64'h1 : 64'h0);
            checkOutput("starve_stall", 64'(ld_stall_dc1), (c == SL) ? 64'h1 : 64'h0);
            applyStimulus();
        end
        setIdle();
        ld_valid_dc1 = 1'b1; ld_addr_dc1 = 16'h0024; ld_end_addr_dc1 = 16'h0027;
        st_req = 1'b1; st_addr = 16'h0004;
        #1;
        checkOutput("starve_restart", 64'(ld_stall_dc1), 64'h0);
        applyStimulus();

        // Scrub and store on bank 0: scrub goes first
        setIdle();
        scrub_req = 1'b1; scrub_addr = 16'h0008; scrub_data = {7'h55, 32'hDEAD_BEEF};
        st_req = 1'b1; st_addr = 16'h0000; st_data = 32'h0BAD_CAFE; st_ecc = 7'h03;
        applyStimulus();
        setIdle();
        st_req = 1'b1; st_addr = 16'h0000; st_data = 32'h0BAD_CAFE; st_ecc = 7'h03;
        #1;
        checkOutput("scrub_first_done", 64'(scrub_done), 64'h1);
        checkOutput("scrub_first_nocommit", 64'(st_commit), 64'h0);
        applyStimulus();
        setIdle();
        st_req = 1'b1; st_addr = 16'h0000; st_data = 32'h0BAD_CAFE; st_ecc = 7'h03;
        #1;
        checkOutput("store_after_scrub", 64'(st_commit), 64'h1);
        applyStimulus();

        // Freeze for three cycles while a load is in flight
        setIdle();
        ld_valid_dc1 = 1'b1; ld_addr_dc1 = 16'h0030; ld_end_addr_dc1 = 16'h0033;
        applyStimulus();
        for (int c = 0; c < 3; c++) begin
            setIdle(); freeze = 1'b1; applyStimulus();
        end
        setIdle(); applyStimulus();
        setIdle();
        #1;
        checkOutput("freeze_valid", 64'(rd_valid_dc3), 64'h1);
        checkOutput("freeze_lo", 64'(rd_data_lo_dc3), 64'(word_of(16'h0030)));
        applyStimulus();

        // Reset while a scrub is pending drops it
        setIdle();
        scrub_req = 1'b1; scrub_addr = 16'h000C; scrub_data = {7'h7F, 32'h0000_1111};
        applyStimulus();
        setIdle(); rst = 1'b1;
        #1;
        checkOutput("rst_pend_busy", 64'(scrub_busy), 64'h1);
        checkOutput("rst_pend_nodone", 64'(scrub_done), 64'h0);
        applyStimulus();
        setIdle();
        #1;
        checkOutput("rst_drop_busy", 64'(scrub_busy), 64'h0);
        applyStimulus();

        // Randomized traffic over a small address window to provoke conflicts
        for (int c = 0; c < 600; c++) begin
            int sz;
            logic [AB-1:0] a;
            setIdle();
            rst    = ($urandom_range(0, 199) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 6) begin
                a = 16'($urandom_range(0, 63));
                sz = 1 << $urandom_range(0, 2);
                ld_valid_dc1 = 1'b1;
                ld_addr_dc1 = a;
                ld_end_addr_dc1 = a + 16'(sz - 1);
            end
            if ($urandom_range(0, 1) == 1) begin
                st_req = 1'b1;
                st_addr = 16'($urandom_range(0, 15) * 4);
                st_data = $urandom;
                st_ecc = 7'($urandom);
            end
            if (!m_pend && $urandom_range(0, 14) == 0) begin
                scrub_req = 1'b1;
                scrub_addr = 16'($urandom_range(0, 15) * 4);
                scrub_data = {7'($urandom), 32'($urandom)};
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
